// File: rtl/button_debouncer_multi.sv
// Multi-channel push-button conditioner: two-flop sync, programmable debounce,
// press/release/event pulses, long-press detection and auto-repeat per channel.

module button_debouncer_lane #(
  parameter bit          ACTIVE_LOW        = 1'b1,
  parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd50000,
  parameter logic [23:0] LONG_PRESS_CYCLES = 24'd6000000,
  parameter logic [23:0] REPEAT_CYCLES     = 24'd1500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_button,
  output logic o_state,
  output logic o_pressed,
  output logic o_released,
  output logic o_event,
  output logic o_long,
  output logic o_repeat
);
  localparam int DW       = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? int'(LONG_PRESS_CYCLES)
                                                                : int'(REPEAT_CYCLES);
  localparam int HW       = $clog2(HOLD_MAX + 1);

  localparam logic [DW-1:0] DB_TERM = DW'(int'(DEBOUNCE_CYCLES) - 1);
  localparam logic [HW-1:0] LP_TERM = HW'(int'(LONG_PRESS_CYCLES) - 1);
  localparam logic [HW-1:0] LP_SAT  = HW'(int'(LONG_PRESS_CYCLES));
  localparam logic [HW-1:0] RP_TERM = HW'((REPEAT_CYCLES == 24'd0) ? 0 : int'(REPEAT_CYCLES) - 1);
  localparam logic          REL     = ACTIVE_LOW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HELD = 2'd1;
  localparam logic [1:0] RPT  = 2'd2;

  logic          r_sync1, r_sync2, r_state;
  logic [DW-1:0] r_db_cnt;
  logic [HW-1:0] r_hold_cnt;
  logic [1:0]    r_fsm;
  logic          r_pressed, r_released, r_event, r_long, r_repeat;
  logic          w_s, w_flip, w_rise, w_fall;

  assign w_s    = ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_flip = (w_s != r_state) && (r_db_cnt == DB_TERM);
  assign w_rise = w_flip & ~r_state;
  assign w_fall = w_flip &  r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= REL;
      r_sync2 <= REL;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= 1'b0;
      r_db_cnt   <= '0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_event    <= 1'b0;
    end else begin
      if (w_s == r_state) begin
        r_db_cnt <= '0;
      end else if (w_flip) begin
        r_state  <= ~r_state;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
      r_pressed  <= w_rise;
      r_released <= w_fall;
      r_event    <= w_flip;
    end
  end

  // Hold FSM looks at the flip happening this edge so a release always beats long/repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= IDLE;
      r_hold_cnt <= '0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      if (w_fall) begin
        r_fsm      <= IDLE;
        r_hold_cnt <= '0;
      end else begin
        case (r_fsm)
          IDLE: if (w_rise) begin
            r_fsm      <= HELD;
            r_hold_cnt <= '0;
          end
          HELD: if (r_hold_cnt == LP_TERM) begin
            r_long   <= 1'b1;
            r_repeat <= (REPEAT_CYCLES != 24'd0);
            if (REPEAT_CYCLES != 24'd0) begin
              r_fsm      <= RPT;
              r_hold_cnt <= '0;
            end else begin
              r_hold_cnt <= LP_SAT;
            end
          end else if (r_hold_cnt < LP_SAT) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
          RPT: if (r_hold_cnt == RP_TERM) begin
            r_repeat   <= 1'b1;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
          default: begin
            r_fsm      <= IDLE;
            r_hold_cnt <= '0;
          end
        endcase
      end
    end
  end

  assign o_state    = r_state;
  assign o_pressed  = r_pressed;
  assign o_released = r_released;
  assign o_event    = r_event;
  assign o_long     = r_long;
  assign o_repeat   = r_repeat;
endmodule

module button_debouncer_multi #(
  parameter int          CHANNELS          = 4,
  parameter bit          ACTIVE_LOW        = 1'b1,
  parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd50000,
  parameter logic [23:0] LONG_PRESS_CYCLES = 24'd6000000,
  parameter logic [23:0] REPEAT_CYCLES     = 24'd1500000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] button_state,
  output logic [CHANNELS-1:0] button_pressed,
  output logic [CHANNELS-1:0] button_released,
  output logic [CHANNELS-1:0] button_event,
  output logic [CHANNELS-1:0] button_long,
  output logic [CHANNELS-1:0] button_repeat
);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    button_debouncer_lane #(
      .ACTIVE_LOW       (ACTIVE_LOW),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_button  (button[g]),
      .o_state   (button_state[g]),
      .o_pressed (button_pressed[g]),
      .o_released(button_released[g]),
      .o_event   (button_event[g]),
      .o_long    (button_long[g]),
      .o_repeat  (button_repeat[g])
    );
  end
endmodule

// File: tb/tb_button_debouncer_multi.sv
// Directed + randomized bench for button_debouncer_multi against a window/elapsed-time model.

module tb_button_debouncer_multi;
  localparam int CH = 2;
  localparam int D  = 4;
  localparam int L  = 20;
  localparam int R  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] button;
  logic [CH-1:0] button_state, button_pressed, button_released;
  logic [CH-1:0] button_event, button_long, button_repeat;

  button_debouncer_multi #(
    .CHANNELS(CH), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(16'd4),
    .LONG_PRESS_CYCLES(24'd20), .REPEAT_CYCLES(24'd8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .button(button),
    .button_state(button_state), .button_pressed(button_pressed),
    .button_released(button_released), .button_event(button_event),
    .button_long(button_long), .button_repeat(button_repeat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: pin history (sync delay), last-D window of normalised samples, press timestamps.
  logic [CH-1:0] pin_hist[$];
  logic [CH-1:0] s_hist[$];
  logic [CH-1:0] m_state, e_pr, e_rl, e_lg, e_rp;
  int            tpress[CH];
  int            ecount;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic mreset();
    pin_hist.delete();
    s_hist.delete();
    m_state = '0; e_pr = '0; e_rl = '0; e_lg = '0; e_rp = '0;
    ecount = 0;
  endtask

  task automatic chk_all();
    chk("state",    32'(button_state),    32'(m_state));
    chk("pressed",  32'(button_pressed),  32'(e_pr));
    chk("released", 32'(button_released), 32'(e_rl));
    chk("event",    32'(button_event),    32'(e_pr | e_rl));
    chk("long",     32'(button_long),     32'(e_lg));
    chk("repeat",   32'(button_repeat),   32'(e_rp));
  endtask

  task automatic step();
    logic [CH-1:0] pin, s, nstate;
    bit            all_diff;
    int            el;
    pin = button;
    @(posedge clk);
    if (!rst_n) begin
      mreset();
    end else begin
      ecount++;
      s = (pin_hist.size() >= 2) ? ~pin_hist[0] : '0;
      pin_hist.push_back(pin);
      if (pin_hist.size() > 2) void'(pin_hist.pop_front());
      s_hist.push_back(s);
      if (s_hist.size() > D) void'(s_hist.pop_front());
      nstate = m_state;
      for (int c = 0; c < CH; c++) begin
        all_diff = (s_hist.size() == D);
        for (int j = 0; j < s_hist.size(); j++)
          if (s_hist[j][c] == m_state[c]) all_diff = 1'b0;
        if (all_diff) nstate[c] = ~m_state[c];
      end
      e_pr = nstate & ~m_state;
      e_rl = m_state & ~nstate;
      for (int c = 0; c < CH; c++) begin
        if (e_pr[c]) tpress[c] = ecount;
        el = ecount - tpress[c];
        e_lg[c] = m_state[c] && nstate[c] && (el == L);
        e_rp[c] = m_state[c] && nstate[c] && (R != 0) && (el >= L) && ((el - L) % R == 0);
      end
      m_state = nstate;
    end
    #1;
    chk_all();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    mreset();
    chk_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int first, n, nlong, long_at, rel_at, nrel, want;
    int runs[4];
    int rl[CH];
    int rep_q[$];
    logic [CH-1:0] snap;

    rst_n = 1'b1;
    button = '1;
    mreset();
    #2;
    async_reset();
    repeat (3) step();
    rst_n = 1'b1;

    // 1: idle after reset
    n = 0;
    repeat (50) begin
      step();
      n += $countones({button_state, button_pressed, button_released,
                       button_event, button_long, button_repeat});
    end
    chk("t1_idle_quiet", n, 0);

    // 2: clean press/release on ch0
    button[0] = 1'b0; first = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (button_pressed[0] && first == 0) first = i;
    end
    chk("t2_press_edge", first, 6);
    button[0] = 1'b1; first = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (button_released[0] && first == 0) first = i;
    end
    chk("t2_release_edge", first, 6);

    // 3: bounce rejection
    runs = '{1, 3, 2, 3};
    n = 0;
    for (int k = 0; k < 4; k++) begin
      button[0] = (k % 2 == 0) ? 1'b0 : 1'b1;
      repeat (runs[k]) begin step(); n += int'(button_event[0]); end
    end
    button[0] = 1'b0; first = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      n += int'(button_event[0]);
      if (button_pressed[0] && first == 0) first = i;
    end
    chk("t3_press_edge", first, 6);
    chk("t3_single_event", n, 1);
    button[0] = 1'b1;
    repeat (10) step();

    // 4: long press and repeat on ch1, debounced release lands on a repeat edge
    button[1] = 1'b0; first = 0;
    for (int i = 1; i <= 10 && first == 0; i++) begin
      step();
      if (button_pressed[1]) first = i;
    end
    chk("t4_press_edge", first, 6);
    nlong = 0; long_at = 0; rel_at = 0; nrel = 0;
    rep_q.delete();
    for (int j = 1; j <= 70; j++) begin
      step();
      if (j == 54) button[1] = 1'b1;
      if (button_long[1]) begin nlong++; long_at = j; end
      if (button_repeat[1]) rep_q.push_back(j);
      if (button_released[1]) begin nrel++; rel_at = j; end
    end
    chk("t4_long_count", nlong, 1);
    chk("t4_long_edge", long_at, 20);
    chk("t4_repeat_count", rep_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      want = 20 + 8 * k;
      chk("t4_repeat_edge", (k < rep_q.size()) ? rep_q[k] : -1, want);
    end
    chk("t4_release_edge", rel_at, 60);
    chk("t4_release_count", nrel, 1);

    // 5: reset mid-hold while in repeat
    button[0] = 1'b0; first = 0;
    for (int i = 1; i <= 10 && first == 0; i++) begin
      step();
      if (button_pressed[0]) first = i;
    end
    repeat (30) step();
    chk("t5_held_before_rst", 32'(button_state[0]), 1);
    async_reset();
    repeat (2) step();
    rst_n = 1'b1;
    first = 0; n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      n += int'(button_released[0]);
      if (button_pressed[0] && first == 0) first = i;
    end
    chk("t5_repress_edge", first, 6);
    chk("t5_no_release", n, 0);
    button[0] = 1'b1;
    repeat (10) step();

    // 6: simultaneous press; ch0 release coincides with its long-press edge
    button = '0; first = 0; snap = '0;
    for (int i = 1; i <= 10 && first == 0; i++) begin
      step();
      if (button_pressed != '0) begin first = i; snap = button_pressed; end
    end
    chk("t6_both_press", 32'(snap), 32'h3);
    chk("t6_press_edge", first, 6);
    nlong = 0; rel_at = 0;
    for (int j = 1; j <= 26; j++) begin
      step();
      if (j == 14) button[0] = 1'b1;
      if (button_long[0]) nlong++;
      if (button_released[0] && rel_at == 0) rel_at = j;
    end
    chk("t6_release_edge", rel_at, 20);
    chk("t6_no_long", nlong, 0);
    button = '1;
    repeat (12) step();

    // random phase: mixed glitches and long holds on both channels
    for (int c = 0; c < CH; c++) rl[c] = $urandom_range(1, 30);
    repeat (600) begin
      for (int c = 0; c < CH; c++) begin
        if (rl[c] == 0) begin
          button[c] = ~button[c];
          rl[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 60);
        end
        rl[c]--;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_debouncer_multi.md
Name: button_debouncer_multi

Overview:
Parametrised multi-channel successor to the single-button debouncer. Each channel does the following:
- synchronises one raw push-button input;
- debounces it with a programmable stable-time;
- emits one-cycle press, release and event pulses;
- adds long-press detection and auto-repeat while held.

It sits between the board button pins and the metronome control logic (tempo up/down, start/stop), so held buttons can step tempo continuously.

Parameters:
CHANNELS, 4, number of independent button channels (>=1).
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed.
DEBOUNCE_CYCLES, 16'd50000, consecutive clk cycles the synchronised input must differ from the stable state before the state flips (>=1).
LONG_PRESS_CYCLES, 24'd6000000, clk cycles after the press pulse until the long-press pulse (>=1).
REPEAT_CYCLES, 24'd1500000, auto-repeat period after long-press; 0 disables repeat.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
button  input  CHANNELS  raw, asynchronous button pins
button_state  output  CHANNELS  debounced level, 1 = pressed (polarity normalised)
button_pressed  output  CHANNELS  1-cycle pulse on debounced press
button_released  output  CHANNELS  1-cycle pulse on debounced release
button_event  output  CHANNELS  pressed OR released, same cycle
button_long  output  CHANNELS  1-cycle pulse when the hold reaches LONG_PRESS_CYCLES
button_repeat  output  CHANNELS  1-cycle pulse at long-press, then every REPEAT_CYCLES while held

Behaviour:
- Reset: asserting rst_n=0 asynchronously clears the following, in every channel:
  - all outputs to 0;
  - debounce and hold counters to 0;
  - per-channel FSM to IDLE;
  - both synchroniser flops to the released level (1 if ACTIVE_LOW, else 0).
- Reset consequences:
  - No pulse is generated by reset itself or by its release.
  - A button held through reset release is seen as a new press after normal debounce latency.
  - Reset mid-hold produces no release pulse.
- Synchroniser: two flops per channel, then polarity normalisation (pressed = 1). The result is called "s".
- Debounce counter (width = $clog2(DEBOUNCE_CYCLES+1)):
  - At each edge where s != button_state, the counter increments.
  - At the edge where the mismatch count reaches DEBOUNCE_CYCLES, button_state flips and the counter clears.
  - Any edge with s == button_state clears the counter. Glitches shorter than DEBOUNCE_CYCLES are ignored entirely.
- Latency: a clean input change (first rising edge after the change counted as 1) flips button_state on edge DEBOUNCE_CYCLES+2.
- Edge pulses:
  - button_pressed and button_released are registered and high in exactly the cycle button_state first shows its new value.
  - button_event is their OR.
  - No pulse is emitted while button_state is unchanged.
- Per-channel FSM, states IDLE, HELD, REPEAT:
  - IDLE -> HELD on debounced press; the hold counter clears to 0.
  - HELD: the hold counter increments each cycle. When it reaches LONG_PRESS_CYCLES:
    - button_long pulses;
    - button_repeat pulses if REPEAT_CYCLES != 0;
    - the counter clears;
    - the FSM goes to REPEAT, or stays parked in HELD with the counter saturated if REPEAT_CYCLES == 0.
  - REPEAT: the counter increments; at REPEAT_CYCLES, button_repeat pulses and the counter clears. This continues indefinitely while held.
  - Any state -> IDLE on debounced release; the counter clears.
- Long/repeat vs release: if a long or repeat pulse would fire on the same edge button_state drops, the release wins and no long/repeat pulse is emitted.
- Counter widths:
  - Hold counter width = $clog2(max(LONG_PRESS_CYCLES, REPEAT_CYCLES)+1).
  - The counter never wraps; it saturates at its terminal value.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- No combinational path from button to any output.

Test Plan:
Bench parameters: CHANNELS=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=8.
1. Reset and idle: rst_n=0 with button=2'b11, then release reset and hold button=2'b11 for 50 cycles -> all outputs stay 0 throughout.
2. Clean press and release on ch0:
   - button[0] 1->0 -> button_state[0]=1 on edge 6, with button_pressed[0] and button_event[0] high for exactly that cycle.
   - Return to 1 after 10 cycles -> button_released[0] pulses on edge 6 after the change.
   - ch1 outputs stay 0.
3. Bounce rejection: button[0] toggles with low/high runs of 1,3,2,3 cycles, then stays low -> no pulses during the bounce; a single press pulse 6 edges after the final falling edge.
4. Long press and repeat: hold ch1 pressed for 60 cycles after the press pulse -> button_long[1] and button_repeat[1] at +20 cycles; further button_repeat[1] at +28, +36, +44, +52; after release no more repeats and one release pulse.
5. Reset mid-hold: ch0 held and in REPEAT, assert rst_n for 2 cycles while still pressed -> outputs 0 with no release pulse; after deassert, a new press pulse on edge 6.
6. Simultaneous and boundary: both channels pressed on the same edge -> both press pulses in the same cycle. Then release ch0 exactly 20 cycles after its press pulse -> release pulse, no button_long[0].
